// File: rtl/vwb_group_writer_if.sv
// Command, result-beat and vRegFile port bundle for the vector write-back group writer.
interface vwb_group_writer_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd_vd;
    logic [2:0]   cmd_sew;
    logic [2:0]   cmd_lmul;
    logic [8:0]   cmd_vl;
    logic         dat_valid;
    logic         dat_ready;
    logic [127:0] dat_data;
    logic [4:0]   old_ra;
    logic [127:0] old_rd;
    logic [4:0]   wa;
    logic [127:0] wd;
    logic         wen;
    logic         done;
    logic         err;

    modport master (
        output cmd_valid, cmd_vd, cmd_sew, cmd_lmul, cmd_vl,
        output dat_valid, dat_data, old_rd,
        input  cmd_ready, dat_ready, old_ra, wa, wd, wen, done, err
    );

    modport slave (
        input  cmd_valid, cmd_vd, cmd_sew, cmd_lmul, cmd_vl,
        input  dat_valid, dat_data, old_rd,
        output cmd_ready, dat_ready, old_ra, wa, wd, wen, done, err
    );
endinterface

// File: rtl/vwb_group_writer.sv
// Writes one register group of ALU results into vRegFile, merging tail elements
// (index >= vl) from the old register contents (tail-undisturbed).
module vwb_group_writer #(
    parameter int unsigned VLEN     = 128,
    parameter int unsigned MAX_LMUL = 8
) (
    input logic              clk,
    input logic              rst,
    vwb_group_writer_if.slave bus
);
    typedef enum logic [0:0] {IDLE, BEAT} state_t;

    state_t       state_q, state_d;
    logic [4:0]   vd_q, vd_d;
    logic [1:0]   sew_q, sew_d;
    logic [2:0]   nregs_m1_q, nregs_m1_d;
    logic [8:0]   vl_eff_q, vl_eff_d;
    logic [$clog2(MAX_LMUL)-1:0] beat_q, beat_d;
    logic         wen_q, wen_d;
    logic         done_q, done_d;
    logic         err_q, err_d;
    logic [4:0]   wa_q, wa_d;
    logic [VLEN-1:0] wd_q, wd_d;

    // command decode
    logic [2:0]   cmd_nregs_m1;
    logic         cmd_lmul_ok;
    logic         cmd_legal;
    logic [8:0]   cmd_limit;
    logic [8:0]   cmd_vl_eff;

    always_comb begin
        cmd_lmul_ok = 1'b1;
        case (bus.cmd_lmul)
            3'b000:  cmd_nregs_m1 = 3'd0;
            3'b001:  cmd_nregs_m1 = 3'd1;
            3'b010:  cmd_nregs_m1 = 3'd3;
            3'b011:  cmd_nregs_m1 = 3'd7;
            3'b100:  begin cmd_nregs_m1 = 3'd0; cmd_lmul_ok = 1'b0; end
            default: cmd_nregs_m1 = 3'd0;
        endcase
        cmd_legal  = cmd_lmul_ok && !bus.cmd_sew[2]
                     && ((bus.cmd_vd & {2'b00, cmd_nregs_m1}) == 5'd0);
        // group capacity in elements: nregs * 16 >> sew
        cmd_limit  = 9'({1'b0, cmd_nregs_m1} + 4'd1) << (3'd4 - {1'b0, bus.cmd_sew[1:0]});
        cmd_vl_eff = (bus.cmd_vl < cmd_limit) ? bus.cmd_vl : cmd_limit;
    end

    // element-level tail merge at byte granularity
    logic [8:0]      beat_base;
    logic [VLEN-1:0] merged;
    logic [8:0]      elem_idx;

    always_comb begin
        case (sew_q)
            2'd0:    beat_base = {2'b00, beat_q, 4'b0000};
            2'd1:    beat_base = {3'b000, beat_q, 3'b000};
            2'd2:    beat_base = {4'b0000, beat_q, 2'b00};
            default: beat_base = {5'b00000, beat_q, 1'b0};
        endcase
        merged   = '0;
        elem_idx = '0;
        for (int unsigned j = 0; j < VLEN / 8; j++) begin
            elem_idx = beat_base + 9'(j >> sew_q);
            merged[j*8 +: 8] = (elem_idx < vl_eff_q) ? bus.dat_data[j*8 +: 8]
                                                     : bus.old_rd[j*8 +: 8];
        end
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.dat_ready = (state_q == BEAT);
    assign bus.old_ra    = vd_q + {2'b00, beat_q};
    assign bus.wa        = wa_q;
    assign bus.wd        = wd_q;
    assign bus.wen       = wen_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    always_comb begin
        state_d    = state_q;
        vd_d       = vd_q;
        sew_d      = sew_q;
        nregs_m1_d = nregs_m1_q;
        vl_eff_d   = vl_eff_q;
        beat_d     = beat_q;
        wen_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (!cmd_legal) begin
                        err_d = 1'b1;
                    end else if (bus.cmd_vl == 9'd0) begin
                        done_d = 1'b1;
                    end else begin
                        vd_d       = bus.cmd_vd;
                        sew_d      = bus.cmd_sew[1:0];
                        nregs_m1_d = cmd_nregs_m1;
                        vl_eff_d   = cmd_vl_eff;
                        beat_d     = '0;
                        state_d    = BEAT;
                    end
                end
            end
            BEAT: begin
                if (bus.dat_valid) begin
                    wen_d = 1'b1;
                    wa_d  = bus.old_ra;
                    wd_d  = merged;
                    if (beat_q == nregs_m1_q) begin
                        done_d  = 1'b1;
                        beat_d  = '0;
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            vd_q       <= '0;
            sew_q      <= '0;
            nregs_m1_q <= '0;
            vl_eff_q   <= '0;
            beat_q     <= '0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            vd_q       <= vd_d;
            sew_q      <= sew_d;
            nregs_m1_q <= nregs_m1_d;
            vl_eff_q   <= vl_eff_d;
            beat_q     <= beat_d;
            wen_q      <= wen_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end
endmodule

// File: tb/tb_vwb_group_writer.sv
// Directed self-checking bench for vwb_group_writer: write-back, tail merge, errors and reset.
module tb_vwb_group_writer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    vwb_group_writer_if bus ();

    vwb_group_writer #(.VLEN(128), .MAX_LMUL(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a command for one cycle; returns with the registered err/done visible.
    task automatic send_cmd(input logic [4:0] vd, input logic [2:0] sew, input logic [2:0] lmul,
                            input logic [8:0] vl);
        bus.cmd_vd    = vd;
        bus.cmd_sew   = sew;
        bus.cmd_lmul  = lmul;
        bus.cmd_vl    = vl;
        bus.cmd_valid = 1'b1;
        check("cmd_ready", 128'(bus.cmd_ready), 128'd1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    // Offers one result beat; checks the read address before and the write after the edge.
    task automatic beat(input string tag, input logic [4:0] exp_ra, input logic [127:0] data,
                        input logic [127:0] old, input logic [127:0] exp_wd, input logic exp_done);
        bus.dat_valid = 1'b1;
        bus.dat_data  = data;
        bus.old_rd    = old;
        check({tag, "_ra"}, 128'(bus.old_ra), 128'(exp_ra));
        check({tag, "_dat_ready"}, 128'(bus.dat_ready), 128'd1);
        tick();
        bus.dat_valid = 1'b0;
        check({tag, "_wen"}, 128'(bus.wen), 128'd1);
        check({tag, "_wa"}, 128'(bus.wa), 128'(exp_ra));
        check({tag, "_wd"}, bus.wd, exp_wd);
        check({tag, "_done"}, 128'(bus.done), 128'(exp_done));
    endtask

    task automatic err_case(input string tag, input logic [4:0] vd, input logic [2:0] sew,
                            input logic [2:0] lmul);
        send_cmd(vd, sew, lmul, 9'd8);
        check({tag, "_err"}, 128'(bus.err), 128'd1);
        check({tag, "_wen"}, 128'(bus.wen), 128'd0);
        check({tag, "_done"}, 128'(bus.done), 128'd0);
        tick();
        check({tag, "_err_clr"}, 128'(bus.err), 128'd0);
        check({tag, "_idle"}, 128'(bus.cmd_ready), 128'd1);
    endtask

    logic [127:0] d0, d1, d2, d3;
    int unsigned gap;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_vd    = '0;
        bus.cmd_sew   = '0;
        bus.cmd_lmul  = '0;
        bus.cmd_vl    = '0;
        bus.dat_valid = 1'b0;
        bus.dat_data  = '0;
        bus.old_rd    = '0;
        tick();
        tick();
        check("rst_wen", 128'(bus.wen), 128'd0);
        check("rst_done", 128'(bus.done), 128'd0);
        check("rst_err", 128'(bus.err), 128'd0);
        check("rst_wa", 128'(bus.wa), 128'd0);
        check("rst_wd", bus.wd, 128'd0);
        check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("rst_dat_ready", 128'(bus.dat_ready), 128'd0);
        rst = 1'b1;
        tick();

        // reset mid-group: pending second beat must never be written
        send_cmd(5'd2, 3'b000, 3'b001, 9'd32);
        check("mid_busy", 128'(bus.cmd_ready), 128'd0);
        beat("mid_b0", 5'd2, {16{8'h3C}}, '0, {16{8'h3C}}, 1'b0);
        bus.dat_valid = 1'b1;
        bus.dat_data  = {16{8'h77}};
        rst = 1'b0;
        tick();
        tick();
        check("mid_rst_wen", 128'(bus.wen), 128'd0);
        check("mid_rst_done", 128'(bus.done), 128'd0);
        check("mid_rst_wd", bus.wd, 128'd0);
        rst = 1'b1;
        check("mid_rel_cmd_ready", 128'(bus.cmd_ready), 128'd1);
        check("mid_rel_dat_ready", 128'(bus.dat_ready), 128'd0);
        tick();
        bus.dat_valid = 1'b0;
        check("mid_rel_wen", 128'(bus.wen), 128'd0);
        check("mid_rel_wd", bus.wd, 128'd0);

        // single register, SEW=32, vl fills it exactly
        send_cmd(5'd3, 3'b010, 3'b000, 9'd4);
        beat("t2", 5'd3, {16{8'hA5}}, '0, {16{8'hA5}}, 1'b1);
        check("t2_idle", 128'(bus.cmd_ready), 128'd1);
        tick();
        check("t2_wen_pulse", 128'(bus.wen), 128'd0);
        check("t2_done_pulse", 128'(bus.done), 128'd0);
        check("t2_wa_hold", 128'(bus.wa), 128'd3);
        check("t2_wd_hold", bus.wd, {16{8'hA5}});

        // LMUL=2, SEW=8, vl=20: second register keeps upper 12 bytes
        send_cmd(5'd4, 3'b000, 3'b001, 9'd20);
        beat("t3_b0", 5'd4, {16{8'hFF}}, {16{8'h11}}, {16{8'hFF}}, 1'b0);
        beat("t3_b1", 5'd5, {16{8'hFF}}, {16{8'h11}}, {{12{8'h11}}, {4{8'hFF}}}, 1'b1);

        // LMUL=4, SEW=16, vl=100 clamps to 32: every element from data, back-to-back beats
        d0 = {8{16'h1000}};
        d1 = {8{16'h2111}};
        d2 = {8{16'h3222}};
        d3 = {8{16'h4333}};
        send_cmd(5'd8, 3'b001, 3'b010, 9'd100);
        beat("t4_b0", 5'd8, d0, {16{8'hEE}}, d0, 1'b0);
        beat("t4_b1", 5'd9, d1, {16{8'hEE}}, d1, 1'b0);
        beat("t4_b2", 5'd10, d2, {16{8'hEE}}, d2, 1'b0);
        beat("t4_b3", 5'd11, d3, {16{8'hEE}}, d3, 1'b1);

        // SEW=64, vl=1: only the low doubleword comes from data
        send_cmd(5'd1, 3'b011, 3'b000, 9'd1);
        beat("sew64", 5'd1, {2{64'hDEAD_BEEF_0123_4567}}, {2{64'h5555_6666_7777_8888}},
             {64'h5555_6666_7777_8888, 64'hDEAD_BEEF_0123_4567}, 1'b1);

        // fractional LMUL is one register; SEW=8 vl=9
        send_cmd(5'd7, 3'b000, 3'b110, 9'd9);
        beat("frac", 5'd7, {16{8'hC3}}, {16{8'h00}}, {{7{8'h00}}, {9{8'hC3}}}, 1'b1);

        err_case("e_lmul", 5'd0, 3'b000, 3'b100);
        err_case("e_align", 5'd5, 3'b000, 3'b001);
        err_case("e_sew", 5'd0, 3'b100, 3'b000);

        // vl=0 retires immediately; next command accepted right after, with gaps between beats
        send_cmd(5'd10, 3'b000, 3'b000, 9'd0);
        check("vl0_done", 128'(bus.done), 128'd1);
        check("vl0_wen", 128'(bus.wen), 128'd0);
        check("vl0_idle", 128'(bus.cmd_ready), 128'd1);
        send_cmd(5'd6, 3'b000, 3'b001, 9'd24);
        check("g_done_clr", 128'(bus.done), 128'd0);
        gap = $urandom_range(1, 3);
        for (int unsigned k = 0; k < gap; k++) begin
            tick();
            check("g_gap0_wen", 128'(bus.wen), 128'd0);
        end
        beat("g_b0", 5'd6, {16{8'h9A}}, {16{8'h44}}, {16{8'h9A}}, 1'b0);
        gap = $urandom_range(1, 3);
        for (int unsigned k = 0; k < gap; k++) begin
            check("g_gap1_ra", 128'(bus.old_ra), 128'd7);
            tick();
            check("g_gap1_wen", 128'(bus.wen), 128'd0);
            check("g_gap1_done", 128'(bus.done), 128'd0);
        end
        beat("g_b1", 5'd7, {16{8'h9A}}, {16{8'h44}}, {{8{8'h44}}, {8{8'h9A}}}, 1'b1);
        tick();
        check("end_idle", 128'(bus.cmd_ready), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
